// File: rtl/bus_grant_scheduler.sv
// Round-robin grant scheduler for the shared 32-source datapath bus.
// Registered one-hot grant plus binary select, with a hold-time limit.
module bus_grant_scheduler #(
  parameter int NREQ     = 32,
  parameter int SELW     = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] sel,
  output logic            grant_valid,
  output logic            preempt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state, state_d;
  logic [SELW-1:0] ptr, ptr_d;
  logic [SELW-1:0] sel_d, win;
  logic [7:0]      hold_cnt, hold_d;
  logic [NREQ-1:0] grant_d, cand;
  logic            preempt_d, found, take, owner_req;

  // The owner is masked out so a timeout always lands on someone else.
  assign cand      = (state == OWNED) ? (req & ~grant) : req;
  assign owner_req = |(req & grant);

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && cand[ptr + SELW'(i)]) begin
        found = 1'b1;
        win   = ptr + SELW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    sel_d     = sel;
    ptr_d     = ptr;
    hold_d    = hold_cnt;
    preempt_d = 1'b0;
    take      = 1'b0;
    unique case (state)
      IDLE: take = found;
      OWNED: begin
        if (!owner_req) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (hold_cnt == HOLD_LAST && found) begin
          take      = 1'b1;
          preempt_d = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_d = hold_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = OWNED;
      grant_d = NREQ'(1) << win;
      sel_d   = win;
      ptr_d   = win + SELW'(1);
      hold_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      sel      <= sel_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_d;
      preempt  <= preempt_d;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: doc/bus_grant_scheduler.md
Name: bus_grant_scheduler

Overview:
- Round-robin scheduler for the shared 32-source datapath bus.
- Takes up to 32 drive requests and grants exactly one source at a time.
- Emits the grant both as a one-hot vector and as a registered 5-bit binary select for the bus multiplexer.
- Enforces a maximum hold time so that no source can starve the others.

Parameters:
- NREQ, 32, number of requesters; fixed at 32 because SELW is 5.
- SELW, 5, select width.
- MAX_HOLD, 8, maximum consecutive grant cycles while another request is pending; legal range 1..255.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- req  in  32  request vector; bit k high means source k wants the bus.
- grant  out  32  one-hot grant, registered; all zero when idle.
- sel  out  5  binary index of the granted source, registered.
- grant_valid  out  1  high when exactly one grant bit is set.
- preempt  out  1  one-cycle pulse on the cycle a grant is taken by timeout.

Behaviour:
- Reset: when clear is high at a clock edge, the following values load.
  - grant=0, sel=5'b00000, grant_valid=0, preempt=0.
  - State IDLE, rotation pointer ptr=0, hold_cnt=0.
  - clear overrides every other input, including mid-grant; the grant drops on the edge that samples clear.
- States: IDLE and OWNED.
- Arbitration function: the winner is the first set bit of req, searching upward from ptr and wrapping from 31 to 0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, on the next edge: grant=onehot(winner), sel=winner, grant_valid=1, ptr=winner+1 mod 32, hold_cnt=0, go to OWNED.
  - Latency from req sampled to grant visible is 1 cycle.
- OWNED, with owner = sel:
  - Release: if req[owner]==0 at an edge, re-arbitrate over the current req on the same edge, so there is no dead cycle between owners.
    - If another request exists, grant the winner and reset hold_cnt.
    - Otherwise, clear grant and return to IDLE. sel keeps its last value; grant_valid=0.
  - Timeout: if req[owner]==1, hold_cnt==MAX_HOLD-1, and any other req bit is set, grant the winner among the others.
    - Because ptr is already owner+1, the owner wins only if it is the sole requester.
    - Set preempt=1 for that cycle and reset hold_cnt.
  - Hold: if req[owner]==1 and no timeout applies, keep the grant and do hold_cnt=min(hold_cnt+1, MAX_HOLD-1).
    - With no competing requests the counter saturates and the owner keeps the bus indefinitely.
- Simultaneous release and timeout: release takes precedence; preempt stays 0.
- ptr update: ptr is updated only on a new grant, never on hold.
  - Wrap-around: a grant to source 31 sets ptr=0.
- Invariants on every cycle:
  - grant has zero or one bit set.
  - grant_valid == |grant.
  - When grant_valid=1, sel == index of grant.
- preempt is low on every cycle other than a timeout hand-over.
- req is assumed synchronous to clock; no internal synchronizers.

Test Plan:
- Reset: hold clear=1 with req=32'hFFFFFFFF, then release clear.
  - While clear is asserted: grant=0, sel=0, grant_valid=0.
  - First edge with clear=0: grant=32'h1, sel=0.
- Rotation: hold req=32'h0000_0015 (sources 0, 2, 4), each dropping its request one cycle after being granted.
  - Required grant order: 0→2→4→0, with no idle cycle between owners.
  - sel sequence: 0, 2, 4, 0.
- Wrap-around: start with sole requester 31 and let it complete, then assert req=32'h8000_0001.
  - Source 31 is granted first, which sets ptr=0.
  - On its release, source 0 is granted, sel=0.
- Timeout, MAX_HOLD=8: source 5 is held continuously with req bit 9 high from cycle 0.
  - Source 5 keeps the grant for exactly 8 cycles.
  - The grant then moves to 9 with preempt pulsed for 1 cycle.
  - Source 5 is granted again only after 9 releases or times out.
- Sole requester: only source 7 is held for 50 cycles.
  - grant=32'h80 throughout, preempt never asserts, hold_cnt saturates.
- Reset mid-grant: while source 12 owns the bus, assert clear for 1 cycle with req unchanged.
  - The grant drops on that edge.
  - After release, re-arbitration restarts from ptr=0 and source 12 is granted again.
